j_sine_phase_reader: RTL
========================

// Module: j_sine_phase_reader
// PURPOSE
// - DSP-side sequencer feeding the sine ROM stage and consuming its data: steps a phase
//   accumulator, drives roma/romen for the ROM, captures the 16-bit ROM word and presents
//   a 32-bit sample to the DSP datapath over a valid/ready handshake.
// - Sits between the DSP register file/control (start, phase, count) and the sine ROM read port.
// PARAMETERS
// - PHASE_W   22  phase accumulator width; ROM address = phase[PHASE_W-1 -: ROM_AW]
// - ROM_AW    10  sine ROM address width
// - DATA_W    16  ROM data width
// - SIGN_EXT  1   1: sample[31:DATA_W] = rom_data[DATA_W-1]; 0: zero-filled
// PORTS
// - sys_clk       in   1        system clock, all state on rising edge
// - reset         in   1        synchronous, active-high reset
// - start         in   1        begin a burst; sampled only in IDLE
// - abort         in   1        terminate burst; wins over every other event
// - phase_init    in   PHASE_W  starting phase, latched on accepted start
// - phase_inc     in   PHASE_W  phase step per sample, latched on accepted start
// - count         in   16       samples in burst, latched on accepted start
// - roma          out  ROM_AW   ROM address
// - romen         out  1        ROM enable (ROM selects while romen=1 and its clk is low)
// - rom_data      in   DATA_W   ROM read data
// - sample        out  32       captured, extended sample
// - sample_valid  out  1        sample holds valid data
// - sample_ready  in   1        consumer accepts sample
// - busy          out  1        high in any state other than IDLE
// - done          out  1        one-cycle pulse at normal burst completion
// BEHAVIOUR
// - Reset: state=IDLE; roma=0, romen=0, sample=0, sample_valid=0, busy=0, done=0; phase,
//   increment, remaining count=0. Mid-burst reset drops everything; no done pulse.
// - FSM states IDLE, ADDR, CAPT, HOLD.
// - IDLE: start=1 latches phase_init/phase_inc/count. count!=0 -> ADDR; count==0 -> stay IDLE
//   and pulse done next cycle with no ROM access.
// - ADDR: romen=1, roma=phase[PHASE_W-1 -: ROM_AW] -> CAPT.
// - CAPT: romen=1, roma unchanged. At the end-of-cycle edge:
//   - sample <= extend(rom_data)
//   - sample_valid <= 1
//   - phase <= phase+phase_inc (mod 2^PHASE_W)
//   - remaining <= remaining-1
//   - next state HOLD
// - HOLD: romen=0; sample and sample_valid stable until sample_ready=1.
//   - Transfer cycle: sample_valid <= 0; remaining!=0 -> ADDR, else IDLE with done=1 next cycle.
// - Latency: start at cycle N -> romen high N+1..N+2 -> sample_valid high at N+3.
//   Sustained rate is 1 sample per 3 cycles with sample_ready tied high.
// - abort=1 in any state: next cycle IDLE, romen=0, sample_valid=0, no done. Start is
//   ignored while abort=1.
// - start while busy: ignored; latched operands unchanged.
// - Phase wraps silently at 2^PHASE_W; ROM address wraps 0x3FF -> 0x000.
// - romen is never high in IDLE or HOLD; roma holds its last value there.
// TESTING
// - Reset, then idle 5 cycles -> all outputs 0, romen never asserted.
// - phase_init=0, phase_inc=0x1000, count=4, sample_ready=1:
//   - roma 0,1,2,3 in successive ADDR phases
//   - sample_valid at N+3, N+6, N+9, N+12
//   - done pulse one cycle after last transfer
// - phase_init=0x3FF000, phase_inc=0x1000, count=2 -> roma 0x3FF then 0x000.
// - rom_data=0x8001, SIGN_EXT=1 -> sample=0xFFFF8001; rom_data=0x7FFF -> 0x00007FFF.
// - sample_ready low 10 cycles in HOLD -> sample stable, romen 0, no new address until transfer.
// - abort in CAPT of burst count=5 -> IDLE next cycle, valid 0, no done; new start accepted.
//   Also: count=0 start -> done only.

Source files
------------

// File: rtl/j_sine_phase_reader.sv
// Phase-stepping sine ROM sequencer: ADDR/CAPT/HOLD per sample, sample_valid 3 cycles after start.
// Backpressure: sample and sample_valid hold in HOLD until sample_ready; abort returns to IDLE at once.
module j_sine_phase_reader #(
    parameter int PHASE_W  = 22,
    parameter int ROM_AW   = 10,
    parameter int DATA_W   = 16,
    parameter int SIGN_EXT = 1
) (
    input  logic               sys_clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [PHASE_W-1:0] phase_init,
    input  logic [PHASE_W-1:0] phase_inc,
    input  logic [15:0]        count,
    output logic [ROM_AW-1:0]  roma,
    output logic               romen,
    input  logic [DATA_W-1:0]  rom_data,
    output logic [31:0]        sample,
    output logic               sample_valid,
    input  logic               sample_ready,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        CAPT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] phase_step;
    logic [15:0]        remaining;
    logic               ext_bit;
    logic [31:0]        sample_ext;

    assign ext_bit    = (SIGN_EXT != 0) ? rom_data[DATA_W-1] : 1'b0;
    assign sample_ext = {{(32-DATA_W){ext_bit}}, rom_data};

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        romen     = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start && (count != 16'd0)) begin
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                romen     = 1'b1;
                state_nxt = CAPT;
            end
            CAPT: begin
                romen     = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: begin
                if (sample_ready) begin
                    state_nxt = (remaining != 16'd0) ? ADDR : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // abort overrides every other transition, including a start in IDLE
        if (abort) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            roma         <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            done         <= 1'b0;
            phase        <= '0;
            phase_step   <= '0;
            remaining    <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                sample_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            phase      <= phase_init;
                            phase_step <= phase_inc;
                            remaining  <= count;
                            if (count != 16'd0) begin
                                roma <= phase_init[PHASE_W-1 -: ROM_AW];
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    CAPT: begin
                        sample       <= sample_ext;
                        sample_valid <= 1'b1;
                        phase        <= phase + phase_step;
                        remaining    <= remaining - 16'd1;
                    end
                    HOLD: begin
                        if (sample_ready) begin
                            sample_valid <= 1'b0;
                            // phase was already advanced in CAPT, so this is the next address
                            if (remaining != 16'd0) begin
                                roma <= phase[PHASE_W-1 -: ROM_AW];
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
